ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//   Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED LED set, 0xFF reset) to the
//   keyboard over the shared open-drain ps2_clk/ps2_data lines. Performs request-to-send, bit shifting
//   on device-generated clock edges, odd parity, stop bit and device ACK check. Sits beside the PS/2
//   keyboard receiver; busy drives the receiver's inhibit so TX traffic is not decoded as scan codes.
// PARAMETERS
//   INHIBIT_CYCLES  5000     clk cycles ps2_clk is held low before RTS (100 us @ 50 MHz)
//   START_TIMEOUT   750000   max cycles from clock release to first device falling edge (15 ms)
//   XFER_TIMEOUT    100000   max cycles from first falling edge to ACK sampled (2 ms)
// PORTS
//   clk          in   1  system clock
//   clrn         in   1  reset, asynchronous, active-high
//   tx_data      in   8  command byte, captured when tx_valid & tx_ready
//   tx_valid     in   1  request to send tx_data
//   tx_ready     out  1  1 = idle, accepts new byte (== ~busy)
//   ps2_clk      in   1  sensed PS/2 clock line (asynchronous)
//   ps2_data     in   1  sensed PS/2 data line (asynchronous)
//   ps2_clk_oe   out  1  1 = pull ps2_clk low, 0 = release (pad is open-drain)
//   ps2_data_oe  out  1  1 = pull ps2_data low, 0 = release
//   busy         out  1  transaction in progress; receiver inhibit
//   done         out  1  one-cycle pulse at end of every accepted transaction (success or error)
//   err_code     out  2  00 ok, 01 no ACK, 10 start timeout, 11 transfer timeout; valid with done, held
// BEHAVIOUR
// - Reset (async, clrn=1): state IDLE; ps2_clk_oe=0, ps2_data_oe=0, busy=0, tx_ready=1, done=0,
//   err_code=00; sync regs, counters cleared. Reset mid-transaction releases both lines immediately.
// - ps2_clk and ps2_data pass through 3-flop sync; fall = sync[2] & ~sync[1]; dat_s = data sync[2].
// - Accept: tx_valid & tx_ready in IDLE -> latch shift = {~^tx_data, tx_data} (odd parity), bit_cnt=0,
//   busy=1 next cycle. tx_valid while busy is ignored (no queueing).
// - States:
//   IDLE     lines released; wait accept -> INHIBIT.
//   INHIBIT  ps2_clk_oe=1 for INHIBIT_CYCLES; last cycle also set ps2_data_oe=1 (start bit) -> RTS.
//   RTS      ps2_clk_oe=0, ps2_data_oe=1; timer counts; on fall -> SEND and drive bit0;
//            timer reaching START_TIMEOUT -> ERR(10).
//   SEND     on each fall: bit_cnt 1..8 drive data bits 1..7 then parity (LSB first);
//            ps2_data_oe = ~bit. Fall with bit_cnt=9: release data (stop bit = 1) -> ACK.
//            Bit driven 1 clk after fall detected (well inside device clock-low phase).
//   ACK      next fall: dat_s==0 -> WAIT_IDLE, else ERR(01).
//   WAIT_IDLE wait dat_s==1 and ps2_clk sync high -> done=1, err_code=00, IDLE.
//   ERR      release both lines, done=1, err_code as tagged, -> IDLE (no WAIT_IDLE).
// - XFER timer starts at first fall in RTS; reaching XFER_TIMEOUT in SEND/ACK/WAIT_IDLE -> ERR(11).
// - Timers saturate; no counter wraps inside a transaction. bit_cnt is 4 bits, cleared on accept.
// - Falls in IDLE/INHIBIT are ignored (device traffic belongs to the receiver).
// - busy=1 from cycle after accept through cycle done pulses; tx_ready rises cycle after done.
// TESTING (bench models device; use INHIBIT_CYCLES=20, START_TIMEOUT=200, XFER_TIMEOUT=2000)
// - Send 0xED, device clocks 11 bits (period 80 clk), samples on rising edges, ACKs -> sampled
//   bits 0,1,0,1,1,0,1,1,1 parity=1? no: 0xED has 6 ones -> parity 1, stop 1; done, err_code=00.
// - Send 0x00 -> parity bit 1; send 0x01 -> parity 0; check ps2_clk_oe low exactly 20 clk before RTS.
// - Device never clocks -> done at 200 clk after RTS, err_code=10, both oe=0.
// - Device clocks all bits but leaves data high at ACK edge -> done, err_code=01, lines released.
// - Device stops clocking after 4 bits -> done at 2000 clk after first fall, err_code=11.
// - Assert clrn during SEND bit 5 -> oe outputs 0 same cycle, busy=0; next tx_valid of 0xFF succeeds.
// - tx_valid held high with new data during transaction -> ignored; only first byte on the wire.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, shifts a command byte with odd parity
// on device clock falls, then checks the device ACK. busy inhibits the companion receiver.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_TIMEOUT  = 750000,
    parameter int XFER_TIMEOUT   = 100000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic [1:0] err_code
);

    localparam int TMAX = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int XW   = $clog2(XFER_TIMEOUT + 1);

    localparam logic [TW-1:0] INH_PRE    = TW'(INHIBIT_CYCLES - 2);
    localparam logic [TW-1:0] INH_LAST   = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] START_LAST = TW'(START_TIMEOUT - 1);
    localparam logic [XW-1:0] XFER_LAST  = XW'(XFER_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE, ERR
    } state_t;

    state_t        state;
    logic [2:0]    clk_sync;
    logic [2:0]    dat_sync;
    logic [8:0]    shift;
    logic [3:0]    bit_cnt;
    logic [TW-1:0] tmr;
    logic [XW-1:0] xfer;
    logic [1:0]    err_tag;
    logic          fall;
    logic          dat_s;

    assign fall     = clk_sync[2] & ~clk_sync[1];
    assign dat_s    = dat_sync[2];
    assign tx_ready = ~busy;

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            state       <= IDLE;
            clk_sync    <= '0;
            dat_sync    <= '0;
            shift       <= '0;
            bit_cnt     <= '0;
            tmr         <= '0;
            xfer        <= '0;
            err_tag     <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_code    <= '0;
        end else begin
            clk_sync <= {clk_sync[1:0], ps2_clk};
            dat_sync <= {dat_sync[1:0], ps2_data};
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    busy        <= 1'b0;
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    if (tx_valid && !busy) begin
                        shift      <= {~^tx_data, tx_data};
                        bit_cnt    <= '0;
                        tmr        <= '0;
                        busy       <= 1'b1;
                        ps2_clk_oe <= 1'b1;
                        state      <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    tmr <= tmr + 1'b1;
                    // Start bit goes low during the last inhibit cycle so RTS begins with data already low.
                    if (tmr == INH_PRE) ps2_data_oe <= 1'b1;
                    if (tmr == INH_LAST) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b1;
                        tmr         <= '0;
                        state       <= RTS;
                    end
                end
                RTS: begin
                    if (fall) begin
                        ps2_data_oe <= ~shift[0];
                        shift       <= {1'b1, shift[8:1]};
                        bit_cnt     <= 4'd1;
                        xfer        <= '0;
                        state       <= SEND;
                    end else if (tmr >= START_LAST) begin
                        err_tag     <= 2'b10;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        state       <= ERR;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                SEND, ACK, WAIT_IDLE: begin
                    if (xfer >= XFER_LAST) begin
                        err_tag     <= 2'b11;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        state       <= ERR;
                    end else begin
                        xfer <= xfer + 1'b1;
                        if (state == SEND && fall) begin
                            if (bit_cnt == 4'd9) begin
                                ps2_data_oe <= 1'b0;
                                state       <= ACK;
                            end else begin
                                ps2_data_oe <= ~shift[0];
                                shift       <= {1'b1, shift[8:1]};
                                bit_cnt     <= bit_cnt + 1'b1;
                            end
                        end else if (state == ACK && fall) begin
                            if (!dat_s) begin
                                state <= WAIT_IDLE;
                            end else begin
                                err_tag <= 2'b01;
                                state   <= ERR;
                            end
                        end else if (state == WAIT_IDLE && dat_s && clk_sync[2]) begin
                            done     <= 1'b1;
                            err_code <= 2'b00;
                            state    <= IDLE;
                        end
                    end
                end
                ERR: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    done        <= 1'b1;
                    err_code    <= err_tag;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: models the keyboard on the open-drain lines and checks
// frames sampled on device rising edges, error codes and timing against hand-computed values.
module tb_ps2_host_tx;
    logic       clk = 1'b0;
    logic       clrn = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done;
    logic [1:0] err_code;
    logic       dev_clk = 1'b1, dev_data = 1'b1;
    logic       ps2_clk, ps2_data;

    assign ps2_clk  = dev_clk & ~ps2_clk_oe;
    assign ps2_data = dev_data & ~ps2_data_oe;

    int checks = 0, failures = 0;
    int cyc = 0, done_cnt = 0, done_cyc = 0;
    logic [1:0] last_err = 2'b00;
    logic busy_at_done = 1'b0;

    ps2_host_tx #(.INHIBIT_CYCLES(20), .START_TIMEOUT(200), .XFER_TIMEOUT(2000)) dut (
        .clk(clk), .clrn(clrn), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ps2_clk(ps2_clk), .ps2_data(ps2_data), .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
        .busy(busy), .done(done), .err_code(err_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (done) begin
            done_cnt++;
            last_err = err_code;
            done_cyc = cyc;
            busy_at_done = busy;
        end
    end

    task automatic request(input logic [7:0] b, input bit hold);
        @(negedge clk);
        tx_data = b;
        tx_valid = 1'b1;
        @(negedge clk);
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic measure_inhibit(output int n, output logic d_first, output logic d_last);
        n = 0; d_first = 1'bx; d_last = 1'bx;
        while (ps2_clk_oe && n < 1000) begin
            if (n == 0) d_first = ps2_data_oe;
            d_last = ps2_data_oe;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic dev_clock(input int n, input bit ack, output logic [10:0] bits, output int t_fall);
        bits = '0; t_fall = 0;
        repeat (30) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            dev_clk = 1'b0;
            if (i == 0) t_fall = cyc;
            repeat (40) @(negedge clk);
            dev_clk = 1'b1;
            bits[i] = ps2_data;
            repeat (10) @(negedge clk);
            if (i == 9 && ack) dev_data = 1'b0;
            repeat (30) @(negedge clk);
        end
        dev_data = 1'b1;
    endtask

    task automatic wait_done(input int start_cnt, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt != start_cnt) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin failures++; $display("FAIL reset_oe got=%b exp=00", {ps2_clk_oe, ps2_data_oe}); end
        checks++; if ({busy, tx_ready, done} !== 3'b010) begin failures++; $display("FAIL reset_flags got=%b exp=010", {busy, tx_ready, done}); end
        checks++; if (err_code !== 2'b00) begin failures++; $display("FAIL reset_err got=%b exp=00", err_code); end
        clrn = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_send_ok(input logic [7:0] b, input logic [10:0] exp_frame);
        int n0, n, tf; logic df, dl; logic [10:0] bits; bit ok;
        n0 = done_cnt;
        request(b, 1'b0);
        checks++; if ({busy, tx_ready} !== 2'b10) begin failures++; $display("FAIL accept_busy b=%h got=%b exp=10", b, {busy, tx_ready}); end
        measure_inhibit(n, df, dl);
        checks++; if (n !== 20) begin failures++; $display("FAIL inhibit_len b=%h got=%0d exp=20", b, n); end
        checks++; if ({df, dl} !== 2'b01) begin failures++; $display("FAIL start_bit_timing b=%h got=%b exp=01", b, {df, dl}); end
        checks++; if (ps2_data_oe !== 1'b1) begin failures++; $display("FAIL rts_data b=%h got=%b exp=1", b, ps2_data_oe); end
        dev_clock(11, 1'b1, bits, tf);
        wait_done(n0, 200, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL send_done_timeout b=%h got=0 exp=1", b); end
        checks++; if (bits !== exp_frame) begin failures++; $display("FAIL frame b=%h got=%h exp=%h", b, bits, exp_frame); end
        checks++; if (last_err !== 2'b00) begin failures++; $display("FAIL send_err b=%h got=%b exp=00", b, last_err); end
        checks++; if (busy_at_done !== 1'b1) begin failures++; $display("FAIL busy_at_done b=%h got=%b exp=1", b, busy_at_done); end
        @(negedge clk);
        checks++; if ({tx_ready, ps2_clk_oe, ps2_data_oe} !== 3'b100) begin failures++; $display("FAIL after_done b=%h got=%b exp=100", b, {tx_ready, ps2_clk_oe, ps2_data_oe}); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_start_timeout();
        int n0, n, t0, d; logic df, dl; bit ok;
        n0 = done_cnt;
        request(8'h55, 1'b0);
        measure_inhibit(n, df, dl);
        t0 = cyc;
        wait_done(n0, 400, ok);
        d = done_cyc - t0;
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL start_to_done got=0 exp=1"); end
        checks++; if (d < 199 || d > 203) begin failures++; $display("FAIL start_to_time got=%0d exp=199..203", d); end
        checks++; if (last_err !== 2'b10) begin failures++; $display("FAIL start_to_err got=%b exp=10", last_err); end
        @(negedge clk);
        checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin failures++; $display("FAIL start_to_oe got=%b exp=00", {ps2_clk_oe, ps2_data_oe}); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_nack();
        int n0, n, tf; logic df, dl; logic [10:0] bits; bit ok;
        n0 = done_cnt;
        request(8'hF0, 1'b0);
        measure_inhibit(n, df, dl);
        dev_clock(11, 1'b0, bits, tf);
        wait_done(n0, 200, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL nack_done got=0 exp=1"); end
        checks++; if (bits !== 11'h7F0) begin failures++; $display("FAIL nack_frame got=%h exp=7f0", bits); end
        checks++; if (last_err !== 2'b01) begin failures++; $display("FAIL nack_err got=%b exp=01", last_err); end
        checks++; if (done_cnt !== n0 + 1) begin failures++; $display("FAIL nack_pulses got=%0d exp=%0d", done_cnt, n0 + 1); end
        checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin failures++; $display("FAIL nack_oe got=%b exp=00", {ps2_clk_oe, ps2_data_oe}); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_xfer_timeout();
        int n0, n, tf, d; logic df, dl; logic [10:0] bits; bit ok;
        n0 = done_cnt;
        request(8'h3C, 1'b0);
        measure_inhibit(n, df, dl);
        dev_clock(4, 1'b0, bits, tf);
        wait_done(n0, 3000, ok);
        d = done_cyc - tf;
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL xfer_to_done got=0 exp=1"); end
        checks++; if (bits[3:0] !== 4'hC) begin failures++; $display("FAIL xfer_to_bits got=%h exp=c", bits[3:0]); end
        checks++; if (d < 1998 || d > 2010) begin failures++; $display("FAIL xfer_to_time got=%0d exp=1998..2010", d); end
        checks++; if (last_err !== 2'b11) begin failures++; $display("FAIL xfer_to_err got=%b exp=11", last_err); end
        @(negedge clk);
        checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin failures++; $display("FAIL xfer_to_oe got=%b exp=00", {ps2_clk_oe, ps2_data_oe}); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n0, n, tf; logic df, dl; logic [10:0] bits;
        n0 = done_cnt;
        request(8'h5A, 1'b0);
        measure_inhibit(n, df, dl);
        dev_clock(5, 1'b0, bits, tf);
        dev_clk = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (ps2_data_oe !== 1'b1) begin failures++; $display("FAIL mid_bit5 got=%b exp=1", ps2_data_oe); end
        #2 clrn = 1'b1;
        #1;
        checks++; if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b000) begin failures++; $display("FAIL mid_reset got=%b exp=000", {ps2_clk_oe, ps2_data_oe, busy}); end
        dev_clk = 1'b1;
        @(negedge clk);
        clrn = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (done_cnt !== n0) begin failures++; $display("FAIL mid_no_done got=%0d exp=%0d", done_cnt, n0); end
        test_send_ok(8'hFF, 11'h3FF);
    endtask

    task automatic test_back_to_back();
        int n0, n, tf; logic df, dl; logic [10:0] bits; bit ok;
        n0 = done_cnt;
        request(8'h11, 1'b1);
        tx_data = 8'h22;
        measure_inhibit(n, df, dl);
        dev_clock(11, 1'b1, bits, tf);
        tx_valid = 1'b0;
        wait_done(n0, 200, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL hold_done got=0 exp=1"); end
        checks++; if (bits !== 11'h311) begin failures++; $display("FAIL hold_frame got=%h exp=311", bits); end
        repeat (10) @(negedge clk);
        checks++; if ({busy, done_cnt == n0 + 1} !== 2'b01) begin failures++; $display("FAIL hold_single got=%b exp=01", {busy, done_cnt == n0 + 1}); end
    endtask

    initial begin
        test_reset();
        test_send_ok(8'hED, 11'h3ED);
        test_send_ok(8'h00, 11'h300);
        test_send_ok(8'h01, 11'h201);
        test_start_timeout();
        test_nack();
        test_xfer_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
